// File: rtl/frontend_command_definition_pkg.sv
// Shared frontend command definitions for the DRAM global controller request path.
// Word sizes, burst length and the command layout forwarded to the frontend scheduler.
package frontend_command_definition_pkg;

    localparam int unsigned FRONTEND_WORD_SIZE = 32;
    localparam int unsigned BACKEND_WORD_SIZE  = 128;
    // Write beats that make up one backend word.
    localparam int unsigned BURST_BEATS        = BACKEND_WORD_SIZE / FRONTEND_WORD_SIZE;

    // The core_num field is sized for this many cores.
    localparam int unsigned NUM_CORES_DEFAULT  = 4;
    localparam int unsigned CORE_NUM_W         = $clog2(NUM_CORES_DEFAULT);
    localparam int unsigned REQ_ID_W           = 8;
    localparam int unsigned ADDR_W             = 32;

    typedef logic [CORE_NUM_W-1:0] core_num_t;
    typedef logic [REQ_ID_W-1:0]   req_id_t;

    typedef enum logic {
        OpRead  = 1'b0,
        OpWrite = 1'b1
    } op_e;

    typedef struct packed {
        op_e                op;
        core_num_t          core_num;
        req_id_t            request_id;
        logic [ADDR_W-1:0]  address;
    } frontend_command_t;

endpackage

// File: rtl/core_request_arbiter_if.sv
// Core-side and scheduler-side signals of core_request_arbiter.
// o_grant_count exists only when CORE_ARB_GRANT_COUNTER_EN is defined.
interface core_request_arbiter_if #(
    parameter int unsigned NUM_CORES = frontend_command_definition_pkg::NUM_CORES_DEFAULT
);
    import frontend_command_definition_pkg::*;

    logic [NUM_CORES-1:0]                          i_core_request_valid;
    frontend_command_t [NUM_CORES-1:0]             i_core_request;
    logic [NUM_CORES-1:0][FRONTEND_WORD_SIZE-1:0]  i_core_write_data;
    logic [NUM_CORES-1:0]                          i_core_write_data_last;
    logic [NUM_CORES-1:0]                          o_core_ready;
    logic                                          i_scheduler_ready;
    logic                                          o_interconnection_request_valid;
    frontend_command_t                             o_interconnection_request;
    logic [FRONTEND_WORD_SIZE-1:0]                 o_interconnection_write_data;
    logic                                          o_interconnection_write_data_last;
    logic                                          o_protocol_error;
`ifdef CORE_ARB_GRANT_COUNTER_EN
    logic [NUM_CORES-1:0][31:0]                    o_grant_count;

    modport slave (
        input  i_core_request_valid, i_core_request, i_core_write_data, i_core_write_data_last,
        input  i_scheduler_ready,
        output o_core_ready, o_interconnection_request_valid, o_interconnection_request,
        output o_interconnection_write_data, o_interconnection_write_data_last,
        output o_protocol_error, o_grant_count
    );

    modport master (
        output i_core_request_valid, i_core_request, i_core_write_data, i_core_write_data_last,
        output i_scheduler_ready,
        input  o_core_ready, o_interconnection_request_valid, o_interconnection_request,
        input  o_interconnection_write_data, o_interconnection_write_data_last,
        input  o_protocol_error, o_grant_count
    );
`else
    modport slave (
        input  i_core_request_valid, i_core_request, i_core_write_data, i_core_write_data_last,
        input  i_scheduler_ready,
        output o_core_ready, o_interconnection_request_valid, o_interconnection_request,
        output o_interconnection_write_data, o_interconnection_write_data_last,
        output o_protocol_error
    );

    modport master (
        output i_core_request_valid, i_core_request, i_core_write_data, i_core_write_data_last,
        output i_scheduler_ready,
        input  o_core_ready, o_interconnection_request_valid, o_interconnection_request,
        input  o_interconnection_write_data, o_interconnection_write_data_last,
        input  o_protocol_error
    );
`endif

endinterface

// File: rtl/core_request_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first valid requester at or after rr_ptr_i, wrapping.
// Purely combinational; returns a one-hot grant and its index.
module rr_priority_picker #(
    parameter int unsigned NUM_CORES = 4,
    localparam int unsigned IdxW     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] valid_i,
    input  logic [IdxW-1:0]      rr_ptr_i,
    output logic [NUM_CORES-1:0] grant_o,
    output logic [IdxW-1:0]      grant_idx_o
);

    localparam logic [IdxW:0] NumCores = (IdxW + 1)'(NUM_CORES);

    // Scan NUM_CORES candidates starting at rr_ptr_i; the first valid one wins.
    always_comb begin : pick
        logic            found;
        logic [IdxW:0]   sum;
        logic [IdxW-1:0] cand;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            sum = {1'b0, rr_ptr_i} + (IdxW + 1)'(i);
            if (sum >= NumCores) begin
                sum = sum - NumCores;
            end
            cand = sum[IdxW-1:0];
            if (!found && valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/core_request_arbiter.sv
// Shares the scheduler request port among NUM_CORES cores: round-robin for reads and
// write beat 0, then burst lock until the last beat of a backend word is accepted.
// A one-entry output register drives the scheduler and stamps the grant index into
// core_num. Optional per-core grant counters under CORE_ARB_GRANT_COUNTER_EN.
module core_request_arbiter
    import frontend_command_definition_pkg::*;
#(
    parameter int unsigned NUM_CORES   = frontend_command_definition_pkg::NUM_CORES_DEFAULT,
    parameter int unsigned BURST_BEATS = frontend_command_definition_pkg::BURST_BEATS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    core_request_arbiter_if.slave bus
);

    localparam int unsigned     IdxW     = $clog2(NUM_CORES);
    localparam int unsigned     BeatW    = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_BEATS - 1);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_CORES - 1);

    typedef enum logic {
        StIdle,
        StWrite
    } arb_state_e;

    arb_state_e                    state_q, state_d;
    logic [IdxW-1:0]               owner_q, owner_d;
    logic [IdxW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [BeatW-1:0]              beat_cnt_q, beat_cnt_d;
    logic                          out_valid_q, out_valid_d;
    frontend_command_t             out_cmd_q, out_cmd_d;
    logic [FRONTEND_WORD_SIZE-1:0] out_data_q, out_data_d;
    logic                          out_last_q, out_last_d;
    logic                          perr_q, perr_d;

    logic [NUM_CORES-1:0]          pick_grant;
    logic [IdxW-1:0]               pick_idx;
    logic [NUM_CORES-1:0]          grant;
    logic [IdxW-1:0]               grant_idx;
    logic [NUM_CORES-1:0]          core_ready;
    logic                          core_xfer;
    frontend_command_t             sel_cmd;
    logic [FRONTEND_WORD_SIZE-1:0] sel_data;
    logic                          sel_last_in;
    logic                          exp_last;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        return (idx == LastIdx) ? '0 : idx + 1'b1;
    endfunction

    rr_priority_picker #(
        .NUM_CORES (NUM_CORES)
    ) u_picker (
        .valid_i     (bus.i_core_request_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (pick_grant),
        .grant_idx_o (pick_idx)
    );

    // Grant selection: round-robin when idle, pinned to the owner during a write burst.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (state_q == StWrite) begin
            grant[owner_q] = 1'b1;
            grant_idx      = owner_q;
        end else begin
            grant     = pick_grant;
            grant_idx = pick_idx;
        end
    end

    // Ready only while the output stage is empty or draining this cycle.
    always_comb begin
        core_ready  = (!out_valid_q || bus.i_scheduler_ready) ? grant : '0;
        core_xfer   = |(bus.i_core_request_valid & core_ready);
        sel_cmd     = bus.i_core_request[grant_idx];
        sel_data    = bus.i_core_write_data[grant_idx];
        sel_last_in = bus.i_core_write_data_last[grant_idx];
        // Reads are single-beat; write bursts end on the counter, never on the input flag.
        if (state_q == StIdle) begin
            exp_last = (sel_cmd.op == OpRead) || (LastBeat == '0);
        end else begin
            exp_last = (beat_cnt_q == LastBeat);
        end
    end

    // Next-state for the FSM, round-robin pointer, output register and error flag.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_cmd_d   = out_cmd_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        perr_d      = perr_q;
        if (core_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = exp_last;
            if (sel_last_in != exp_last) begin
                perr_d = 1'b1;
            end
            if (state_q == StIdle) begin
                out_cmd_d          = sel_cmd;
                out_cmd_d.core_num = core_num_t'(grant_idx);
                if (sel_cmd.op == OpWrite) begin
                    state_d    = StWrite;
                    owner_d    = grant_idx;
                    beat_cnt_d = BeatW'(1);
                end else begin
                    rr_ptr_d = next_idx(grant_idx);
                end
            end else if (beat_cnt_q == LastBeat) begin
                state_d    = StIdle;
                beat_cnt_d = '0;
                rr_ptr_d   = next_idx(owner_q);
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end else if (out_valid_q && bus.i_scheduler_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_cmd_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_cmd_q   <= out_cmd_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            perr_q      <= perr_d;
        end
    end

    assign bus.o_core_ready                      = core_ready;
    assign bus.o_interconnection_request_valid   = out_valid_q;
    assign bus.o_interconnection_request         = out_cmd_q;
    assign bus.o_interconnection_write_data      = out_data_q;
    assign bus.o_interconnection_write_data_last = out_last_q;
    assign bus.o_protocol_error                  = perr_q;

`ifdef CORE_ARB_GRANT_COUNTER_EN
    logic [NUM_CORES-1:0][31:0] grant_cnt_q, grant_cnt_d;

    // Count one grant per request, i.e. per beat-0 transfer; wraps naturally.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (core_xfer && (state_q == StIdle)) begin
            grant_cnt_d[grant_idx] = grant_cnt_q[grant_idx] + 32'd1;
        end
    end

    // Grant counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign bus.o_grant_count = grant_cnt_q;
`endif

endmodule

// File: tb/tb_core_request_arbiter.sv
// Self-checking bench for core_request_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin reference model.
module tb_core_request_arbiter;
    import frontend_command_definition_pkg::*;

    localparam int unsigned NC   = 4;
    localparam int unsigned BB   = 4;
    localparam int unsigned CmdW = $bits(frontend_command_t);

    typedef struct packed {
        frontend_command_t cmd;
        logic [3:0][31:0]  data;
        logic [3:0]        lastv;
    } txn_t;

    typedef struct packed {
        frontend_command_t cmd;
        logic [31:0]       data;
        logic              last;
    } beat_t;

    typedef struct packed {
        logic [NC-1:0] rdy;
        logic          ov;
        logic          perr;
        beat_t         ob;
    } tr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_request_arbiter_if #(.NUM_CORES(NC)) bus ();

    core_request_arbiter #(
        .NUM_CORES   (NC),
        .BURST_BEATS (BB)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    txn_t  tq[NC][16];
    int    tq_n[NC];
    int    start_cyc[NC];
    int    pos[NC];
    int    bt[NC];
    beat_t obs[$];
    beat_t expq[$];
    tr_t   trace[$];
    bit    timed_out;
    int    n_cmp = 0;
    int    n_fail = 0;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic txn_t mk_txn(input bit wr, input logic [3:0] lastv);
        txn_t        t;
        logic [63:0] r;
        r      = {$urandom(), $urandom()};
        t.cmd  = frontend_command_t'(r[CmdW-1:0]);
        t.cmd.op = wr ? OpWrite : OpRead;
        for (int b = 0; b < 4; b++) t.data[b] = $urandom();
        t.lastv = lastv;
        return t;
    endfunction

    function automatic beat_t exp_beat(input frontend_command_t c, input int k,
                                       input logic [31:0] d, input logic l);
        beat_t e;
        e.cmd          = c;
        e.cmd.core_num = core_num_t'(k);
        e.data         = d;
        e.last         = l;
        return e;
    endfunction

    task automatic clear_txns();
        for (int k = 0; k < NC; k++) begin
            tq_n[k]      = 0;
            start_cyc[k] = 0;
        end
    endtask

    task automatic add_txn(input int k, input txn_t t);
        tq[k][tq_n[k]] = t;
        tq_n[k]++;
    endtask

    task automatic drive_idle();
        bus.i_core_request_valid   = '0;
        bus.i_core_request         = '0;
        bus.i_core_write_data      = '0;
        bus.i_core_write_data_last = '0;
        bus.i_scheduler_ready      = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Transaction-level reference: whole requests served in round-robin order among
    // cores that still have work; a write contributes BB beats, last only on the final one.
    task automatic build_expected();
        int p[NC];
        int ptr;
        int found;
        int nb;
        expq.delete();
        ptr = 0;
        for (int k = 0; k < NC; k++) p[k] = 0;
        forever begin
            found = -1;
            for (int i = 0; i < NC; i++) begin
                if (found < 0 && p[(ptr + i) % NC] < tq_n[(ptr + i) % NC]) found = (ptr + i) % NC;
            end
            if (found < 0) break;
            nb = (tq[found][p[found]].cmd.op == OpWrite) ? BB : 1;
            for (int b = 0; b < nb; b++) begin
                expq.push_back(exp_beat(tq[found][p[found]].cmd, found,
                                        tq[found][p[found]].data[b], b == nb - 1));
            end
            p[found]++;
            ptr = (found + 1) % NC;
        end
    endtask

    // Behaves like NC cores plus a scheduler; records a per-cycle trace and accepted beats.
    task automatic run_engine(input int max_cyc, input int pct, input int stall_at,
                              input int stall_len);
        int            cyc;
        logic [NC-1:0] acc;
        logic [63:0]   r;
        bit            busy;
        tr_t           tr;
        obs.delete();
        trace.delete();
        timed_out = 1'b0;
        cyc = 0;
        for (int k = 0; k < NC; k++) begin
            pos[k] = 0;
            bt[k]  = 0;
        end
        forever begin
            for (int k = 0; k < NC; k++) begin
                r = {$urandom(), $urandom()};
                if (cyc >= start_cyc[k] && pos[k] < tq_n[k]) begin
                    bus.i_core_request_valid[k]   = 1'b1;
                    bus.i_core_request[k]         = (bt[k] == 0) ? tq[k][pos[k]].cmd
                                                                 : frontend_command_t'(r[CmdW-1:0]);
                    bus.i_core_write_data[k]      = tq[k][pos[k]].data[bt[k]];
                    bus.i_core_write_data_last[k] = tq[k][pos[k]].lastv[bt[k]];
                end else begin
                    bus.i_core_request_valid[k]   = 1'b0;
                    bus.i_core_request[k]         = frontend_command_t'(r[CmdW-1:0]);
                    bus.i_core_write_data[k]      = r[31:0];
                    bus.i_core_write_data_last[k] = r[63];
                end
            end
            if (cyc >= stall_at && cyc < stall_at + stall_len) bus.i_scheduler_ready = 1'b0;
            else bus.i_scheduler_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            tr.rdy      = bus.o_core_ready;
            tr.ov       = bus.o_interconnection_request_valid;
            tr.perr     = bus.o_protocol_error;
            tr.ob.cmd   = bus.o_interconnection_request;
            tr.ob.data  = bus.o_interconnection_write_data;
            tr.ob.last  = bus.o_interconnection_write_data_last;
            trace.push_back(tr);
            if (tr.ov && bus.i_scheduler_ready) obs.push_back(tr.ob);
            acc = bus.i_core_request_valid & bus.o_core_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < NC; k++) begin
                if (acc[k]) begin
                    if (tq[k][pos[k]].cmd.op == OpWrite && bt[k] < BB - 1) begin
                        bt[k]++;
                    end else begin
                        bt[k] = 0;
                        pos[k]++;
                    end
                end
            end
            cyc++;
            busy = 1'b0;
            for (int k = 0; k < NC; k++) if (pos[k] < tq_n[k]) busy = 1'b1;
            if (!busy && !bus.o_interconnection_request_valid) break;
            if (cyc >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
        end
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.o_core_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0", bus.o_core_ready);
        end
        n_cmp++;
        if (bus.o_interconnection_request_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", bus.o_interconnection_request_valid);
        end
        n_cmp++;
        if ({bus.o_interconnection_request, bus.o_interconnection_write_data,
             bus.o_interconnection_write_data_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got %h/%h/%b want 0", bus.o_interconnection_request,
                     bus.o_interconnection_write_data, bus.o_interconnection_write_data_last);
        end
        n_cmp++;
        if (bus.o_protocol_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_perr: got %b want 0", bus.o_protocol_error);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_read_rr();
        int    k;
        beat_t e;
        apply_reset();
        clear_txns();
        for (int c = 0; c < NC; c++) begin
            add_txn(c, mk_txn(1'b0, 4'b0001));
            add_txn(c, mk_txn(1'b0, 4'b0001));
        end
        run_engine(60, 100, -1, 0);
        n_cmp++;
        if (timed_out !== 1'b0 || trace.size() < 9) begin
            n_fail++;
            $display("FAIL rr_run: got timeout=%0b cycles=%0d want 0 and >=9", timed_out,
                     trace.size());
            return;
        end
        n_cmp++;
        if (trace[0].ov !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_first_cycle_valid: got %b want 0", trace[0].ov);
        end
        for (int c = 0; c < 8; c++) begin
            k = c % NC;
            n_cmp++;
            if (trace[c].rdy !== NC'(1 << k)) begin
                n_fail++;
                $display("FAIL rr_grant cycle %0d: got %b want %b", c, trace[c].rdy, NC'(1 << k));
            end
            e = exp_beat(tq[k][c / NC].cmd, k, tq[k][c / NC].data[0], 1'b1);
            n_cmp++;
            if ({trace[c + 1].ov, trace[c + 1].ob} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL rr_out cycle %0d: got %b/%h want 1/%h", c + 1, trace[c + 1].ov,
                         trace[c + 1].ob, e);
            end
        end
    endtask

    task automatic test_write_lock();
        logic [NC-1:0] rdy_exp[5];
        beat_t         e;
        apply_reset();
        clear_txns();
        add_txn(2, mk_txn(1'b1, 4'b1000));
        add_txn(1, mk_txn(1'b0, 4'b0001));
        start_cyc[1] = 1;
        run_engine(60, 100, -1, 0);
        n_cmp++;
        if (timed_out !== 1'b0 || trace.size() < 6) begin
            n_fail++;
            $display("FAIL lock_run: got timeout=%0b cycles=%0d want 0 and >=6", timed_out,
                     trace.size());
            return;
        end
        rdy_exp = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010};
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (trace[c].rdy !== rdy_exp[c]) begin
                n_fail++;
                $display("FAIL lock_grant cycle %0d: got %b want %b", c, trace[c].rdy, rdy_exp[c]);
            end
        end
        for (int b = 0; b < 4; b++) begin
            e = exp_beat(tq[2][0].cmd, 2, tq[2][0].data[b], b == 3);
            n_cmp++;
            if ({trace[b + 1].ov, trace[b + 1].ob} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL lock_beat %0d: got %b/%h want 1/%h", b, trace[b + 1].ov,
                         trace[b + 1].ob, e);
            end
        end
        e = exp_beat(tq[1][0].cmd, 1, tq[1][0].data[0], 1'b1);
        n_cmp++;
        if ({trace[5].ov, trace[5].ob} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL lock_read_after: got %b/%h want 1/%h", trace[5].ov, trace[5].ob, e);
        end
    endtask

    task automatic test_backpressure();
        beat_t e;
        apply_reset();
        clear_txns();
        add_txn(0, mk_txn(1'b1, 4'b1000));
        run_engine(60, 100, 2, 3);
        n_cmp++;
        if (timed_out !== 1'b0 || trace.size() < 5) begin
            n_fail++;
            $display("FAIL bp_run: got timeout=%0b cycles=%0d want 0 and >=5", timed_out,
                     trace.size());
            return;
        end
        e = exp_beat(tq[0][0].cmd, 0, tq[0][0].data[1], 1'b0);
        for (int c = 2; c < 5; c++) begin
            n_cmp++;
            if ({trace[c].rdy, trace[c].ov, trace[c].ob} !== {4'b0000, 1'b1, e}) begin
                n_fail++;
                $display("FAIL bp_frozen cycle %0d: got %b/%b/%h want 0000/1/%h", c,
                         trace[c].rdy, trace[c].ov, trace[c].ob, e);
            end
        end
        n_cmp++;
        if (obs.size() !== 4) begin
            n_fail++;
            $display("FAIL bp_beat_count: got %0d want 4", obs.size());
        end
        for (int b = 0; b < 4 && b < obs.size(); b++) begin
            e = exp_beat(tq[0][0].cmd, 0, tq[0][0].data[b], b == 3);
            n_cmp++;
            if (obs[b] !== e) begin
                n_fail++;
                $display("FAIL bp_beat %0d: got %h want %h", b, obs[b], e);
            end
        end
    endtask

    task automatic test_protocol_error();
        logic [4:0] last_exp;
        apply_reset();
        clear_txns();
        add_txn(1, mk_txn(1'b1, 4'b0010));
        add_txn(1, mk_txn(1'b0, 4'b0001));
        run_engine(60, 100, -1, 0);
        n_cmp++;
        if (timed_out !== 1'b0 || trace.size() < 6) begin
            n_fail++;
            $display("FAIL perr_run: got timeout=%0b cycles=%0d want 0 and >=6", timed_out,
                     trace.size());
            return;
        end
        n_cmp++;
        if ({trace[0].perr, trace[1].perr, trace[2].perr} !== 3'b001) begin
            n_fail++;
            $display("FAIL perr_rise: got %b%b%b want 001", trace[0].perr, trace[1].perr,
                     trace[2].perr);
        end
        n_cmp++;
        if (trace[trace.size() - 1].perr !== 1'b1) begin
            n_fail++;
            $display("FAIL perr_sticky: got %b want 1", trace[trace.size() - 1].perr);
        end
        n_cmp++;
        if (obs.size() !== 5) begin
            n_fail++;
            $display("FAIL perr_beat_count: got %0d want 5", obs.size());
            return;
        end
        last_exp = 5'b11000;
        for (int b = 0; b < 5; b++) begin
            n_cmp++;
            if (obs[b].last !== last_exp[b] || obs[b].cmd.core_num !== core_num_t'(1)) begin
                n_fail++;
                $display("FAIL perr_beat %0d: got last=%b core=%0d want last=%b core=1", b,
                         obs[b].last, obs[b].cmd.core_num, last_exp[b]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        txn_t t;
        txn_t r0;
        apply_reset();
        t  = mk_txn(1'b1, 4'b1000);
        r0 = mk_txn(1'b0, 4'b0001);
        bus.i_scheduler_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus.i_core_request_valid     = 4'b0100;
            bus.i_core_request[2]        = t.cmd;
            bus.i_core_write_data[2]     = t.data[b];
            bus.i_core_write_data_last[2] = t.lastv[b];
            if (b == 2) rst = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.i_core_request_valid      = 4'b0101;
        bus.i_core_request[0]         = r0.cmd;
        bus.i_core_write_data[0]      = r0.data[0];
        bus.i_core_write_data_last[0] = 1'b1;
        bus.i_core_request[2]         = r0.cmd;
        bus.i_core_write_data_last[2] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_interconnection_request_valid, bus.o_interconnection_write_data,
             bus.o_protocol_error} !== '0) begin
            n_fail++;
            $display("FAIL rst_burst_outputs: got %b/%h/%b want 0/0/0",
                     bus.o_interconnection_request_valid, bus.o_interconnection_write_data,
                     bus.o_protocol_error);
        end
        n_cmp++;
        if (bus.o_core_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_burst_first_grant: got %b want 0001", bus.o_core_ready);
        end
        @(posedge clk);
        #1 drive_idle();
        bus.i_scheduler_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_interconnection_request_valid, bus.o_interconnection_request}
            !== {1'b1, exp_beat(r0.cmd, 0, '0, 1'b0).cmd}) begin
            n_fail++;
            $display("FAIL rst_burst_forward: got %b/%h want 1/%h",
                     bus.o_interconnection_request_valid, bus.o_interconnection_request,
                     exp_beat(r0.cmd, 0, '0, 1'b0).cmd);
        end
        @(posedge clk);
        #1 drive_idle();
    endtask

    task automatic test_random();
        int bad_onehot;
        int nt;
        bit wr;
        for (int round = 0; round < 4; round++) begin
            apply_reset();
            clear_txns();
            for (int k = 0; k < NC; k++) begin
                nt = $urandom_range(1, 6);
                for (int i = 0; i < nt; i++) begin
                    wr = $urandom_range(0, 1);
                    add_txn(k, mk_txn(wr, wr ? 4'b1000 : 4'b0001));
                end
            end
            build_expected();
            run_engine(3000, 65, -1, 0);
            n_cmp++;
            if (timed_out !== 1'b0 || obs.size() !== expq.size()) begin
                n_fail++;
                $display("FAIL rand_count round %0d: got timeout=%0b beats=%0d want 0/%0d",
                         round, timed_out, obs.size(), expq.size());
            end
            for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
                n_cmp++;
                if (obs[i] !== expq[i]) begin
                    n_fail++;
                    $display("FAIL rand_beat round %0d idx %0d: got %h want %h", round, i,
                             obs[i], expq[i]);
                end
            end
            bad_onehot = 0;
            foreach (trace[c]) if (!$onehot0(trace[c].rdy)) bad_onehot++;
            n_cmp++;
            if (bad_onehot !== 0 || trace[trace.size() - 1].perr !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_ready_perr round %0d: got %0d multi-grant, perr %b want 0/0",
                         round, bad_onehot, trace[trace.size() - 1].perr);
            end
        end
    endtask

`ifdef CORE_ARB_GRANT_COUNTER_EN
    task automatic test_grant_count();
        logic [31:0] want;
        apply_reset();
        clear_txns();
        for (int i = 0; i < 10; i++) add_txn(3, mk_txn(1'b0, 4'b0001));
        run_engine(200, 50, -1, 0);
        for (int k = 0; k < NC; k++) begin
            want = (k == 3) ? 32'd10 : 32'd0;
            n_cmp++;
            if (bus.o_grant_count[k] !== want) begin
                n_fail++;
                $display("FAIL grant_count core %0d: got %0d want %0d", k, bus.o_grant_count[k],
                         want);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_rr();
        test_write_lock();
        test_backpressure();
        test_protocol_error();
        test_reset_mid_burst();
        test_random();
`ifdef CORE_ARB_GRANT_COUNTER_EN
        test_grant_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
